// File: rtl/serial_alu.sv
// Bit-serial ALU: WIDTH-bit operands, one bit per clock, LSB first.
// Eight ops with start/busy/done handshake and registered flags.
module serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       oper,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t state_q, state_d;

  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_out_q, c_out_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             x_bit;
  logic             y_bit;
  logic             r_bit;
  logic             k_nx;
  logic             arith;
  logic             last;
  logic [WIDTH-1:0] full;

  // One-bit slice: operand inversion, sum/logic bit and next carry
  always_comb begin
    x_bit = a_sh_q[0];
    y_bit = b_sh_q[0];
    arith = 1'b0;
    r_bit = 1'b0;
    k_nx  = cy_q;
    unique case (op_q)
      3'b000: arith = 1'b1;
      3'b001: begin
        arith = 1'b1;
        y_bit = ~b_sh_q[0];
      end
      3'b010: begin
        arith = 1'b1;
        x_bit = ~a_sh_q[0];
      end
      3'b011: r_bit = x_bit | y_bit;
      3'b100: r_bit = x_bit & y_bit;
      3'b101: r_bit = ~x_bit & y_bit;
      3'b110: r_bit = x_bit ^ y_bit;
      3'b111: r_bit = ~(x_bit ^ y_bit);
    endcase
    if (arith) begin
      r_bit = x_bit ^ y_bit ^ cy_q;
      k_nx  = (x_bit & y_bit)
            | (x_bit & cy_q)
            | (y_bit & cy_q);
    end
  end

  assign last = (cnt_q == CW'(WIDTH - 1));
  assign full = {r_bit, r_sh_q[WIDTH-1:1]};

  // Next-state: accept in IDLE, shift one bit per RUN cycle, commit on last
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
    c_out_d = c_out_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = oper;
          a_sh_d  = a;
          b_sh_d  = b;
          cy_d    = (oper == 3'b010) ? ~c_in : c_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        r_sh_d = full;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cy_d   = k_nx;
        cnt_d  = cnt_q + 1'b1;
        if (last) begin
          res_d   = full;
          c_out_d = arith & k_nx;
          ovf_d   = arith & (cy_q ^ k_nx);
          zero_d  = (full == '0);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      c_out_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
      c_out_q <= c_out_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;
  assign c_out  = c_out_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_alu.sv
// Bench for serial_alu: vector table, scoreboard queue,
// handshake, back-to-back and reset-abort sequences.
module tb_serial_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   oper;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c_out;
  logic         zero;
  logic         ovf;

  serial_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .oper   (oper),
    .a      (a),
    .b      (b),
    .c_in   (c_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out),
    .zero   (zero),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         v;
  } vec_t;

  vec_t sbq[$];
  vec_t mon_e;
  vec_t tbl[9];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op,
                              input logic [W-1:0] x,
                              input logic [W-1:0] y,
                              input logic ci,
                              input logic [W-1:0] r,
                              input logic c,
                              input logic z,
                              input logic v);
    vec_t e;
    e.op = op; e.a = x; e.b = y; e.cin = ci;
    e.r = r; e.c = c; e.z = z; e.v = v;
    return e;
  endfunction

  function automatic vec_t model(input logic [2:0] op,
                                 input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic ci);
    vec_t e;
    logic [W:0]   s;
    logic [W-1:0] p;
    logic [W-1:0] q;
    logic         k;
    e.op = op; e.a = x; e.b = y; e.cin = ci;
    e.c = 1'b0; e.v = 1'b0; e.r = '0;
    p = x; q = y; k = ci;
    if (op == 3'd1) q = ~y;
    if (op == 3'd2) begin
      p = ~x;
      k = ~ci;
    end
    if (op <= 3'd2) begin
      s = {1'b0, p} + {1'b0, q} + (W+1)'(k);
      e.r = s[W-1:0];
      e.c = s[W];
      e.v = (p[W-1] == q[W-1]) && (e.r[W-1] != p[W-1]);
    end else begin
      case (op)
        3'd3:    e.r = x | y;
        3'd4:    e.r = x & y;
        3'd5:    e.r = ~x & y;
        3'd6:    e.r = x ^ y;
        default: e.r = ~(x ^ y);
      endcase
    end
    e.z = (e.r == '0);
    return e;
  endfunction

  // Scoreboard: every done pops one expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("result", 32'(result), 32'(mon_e.r));
        chk("c_out", 32'(c_out), 32'(mon_e.c));
        chk("zero", 32'(zero), 32'(mon_e.z));
        chk("ovf", 32'(ovf), 32'(mon_e.v));
      end
    end
  end

  task automatic issue(input vec_t e);
    oper  = e.op;
    a     = e.a;
    b     = e.b;
    c_in  = e.cin;
    start = 1'b1;
    sbq.push_back(e);
  endtask

  task automatic wait_done(input string tag,
                           input bit pulse,
                           input bit keep,
                           input bit hold_chk,
                           input logic [W-1:0] hold_r);
    int lat = 0;
    int bc  = 0;
    bit got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1;
        break;
      end
      lat++;
      if (busy === 1'b1) bc++;
      if (hold_chk && lat == 4)
        chk({tag, "_hold"}, 32'(result), 32'(hold_r));
      start = keep || (pulse && (lat == 3 || lat == 8));
      if (pulse) begin
        a = W'($urandom);
        b = W'($urandom);
      end
    end
    if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(W));
    chk({tag, "_busy_cycles"}, 32'(bc), 32'(W));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    if (!keep) start = 1'b0;
  endtask

  initial begin
    vec_t v;
    tbl[0] = mk(3'b000, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
    tbl[1] = mk(3'b001, 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    tbl[2] = mk(3'b010, 8'h03, 8'h10, 1'b0, 8'h0D, 1'b1, 1'b0, 1'b0);
    tbl[3] = mk(3'b111, 8'hF0, 8'hAA, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    tbl[4] = mk(3'b101, 8'hF0, 8'hAA, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0);
    tbl[5] = mk(3'b011, 8'hF0, 8'hAA, 1'b1, 8'hFA, 1'b0, 1'b0, 1'b0);
    tbl[6] = mk(3'b100, 8'hF0, 8'hAA, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b0);
    tbl[7] = mk(3'b110, 8'hF0, 8'hAA, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    tbl[8] = mk(3'b000, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);

    rst   = 1'b1;
    start = 1'b0;
    oper  = '0;
    a     = '0;
    b     = '0;
    c_in  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      issue(tbl[i]);
      wait_done("vec", 1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
    end

    issue(mk(3'b000, 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0));
    wait_done("ignore", 1'b1, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("ignore_idle_busy", 32'(busy), 32'd0);

    issue(mk(3'b001, 8'h40, 8'h01, 1'b0, 8'h3E, 1'b1, 1'b0, 1'b0));
    wait_done("b2b_first", 1'b0, 1'b1, 1'b0, '0);
    issue(mk(3'b110, 8'h3C, 8'h0F, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0));
    wait_done("b2b_second", 1'b0, 1'b0, 1'b1, 8'h3E);
    @(negedge clk);

    issue(mk(3'b000, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_c_out", 32'(c_out), 32'd0);
    chk("abort_zero", 32'(zero), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_stays_idle", 32'(busy), 32'd0);
    issue(mk(3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0));
    wait_done("post_abort", 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      v = model(3'(i % 8), W'($urandom), W'($urandom), 1'($urandom));
      issue(v);
      wait_done("rand", 1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
